// File: rtl/int_to_shortreal_pkg.sv
// Shared types and constants for the integer-to-shortreal encoder.
// Holds the IEEE-754 single field widths, exponent bias, result bundle and FSM states.
package int_to_shortreal_pkg;

    localparam int SR_EXP_W = 8;
    localparam int SR_MAN_W = 23;
    localparam int SR_BIAS  = 127;

    typedef struct packed {
        logic                sign;
        logic [SR_EXP_W-1:0] exp;
        logic [SR_MAN_W-1:0] man;
    } sr_bits_t;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } enc_state_e;

endpackage

// File: rtl/int_to_shortreal_lzc.sv
// Combinational leading-zero counter used by the single-cycle normaliser.
// Ports: value (IN_W) in, count (LZ_W) out; count is don't-care for value==0.
module int_to_shortreal_lzc
    import int_to_shortreal_pkg::*;
#(
    parameter int IN_W = 32,
    parameter int LZ_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0] value,
    output logic [LZ_W-1:0] count
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        count = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (value[i]) begin
                count = LZ_W'(IN_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_shortreal_enc.sv
// Signed integer to IEEE-754 single encoder, RNE rounding, valid/ready on both sides.
// Ports: clk, rst_n (async low); in_valid/in_ready/in_data[IN_W];
// out_valid/out_ready/out_bits[32]/out_inexact.
// Build option INT_TO_SHORTREAL_FAST_NORM_EN: one-cycle LZC + barrel shift
// instead of the serial one-bit-per-cycle normaliser.
module int_to_shortreal_enc
    import int_to_shortreal_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_bits,
    output logic            out_inexact
);

    localparam int LZ_W  = $clog2(IN_W);
    localparam int EXT_W = IN_W + SR_MAN_W + 1;

    enc_state_e      state_q, state_d;
    logic [IN_W-1:0] mag_q, mag_d;
    logic [LZ_W-1:0] lz_q, lz_d;
    logic            sign_q, sign_d;
    sr_bits_t        out_bits_q, out_bits_d;
    logic            out_inexact_q, out_inexact_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [EXT_W-1:0]    ext;
    logic [SR_MAN_W-1:0] man_trunc;
    logic                guard;
    logic                sticky;
    logic                round_up;
    logic [SR_MAN_W:0]   man_sum;
    logic [SR_EXP_W-1:0] exp_sum;
    sr_bits_t            rnd_bits;

`ifdef INT_TO_SHORTREAL_FAST_NORM_EN
    logic [LZ_W-1:0] lzc_count;

    int_to_shortreal_lzc #(
        .IN_W (IN_W),
        .LZ_W (LZ_W)
    ) u_lzc (
        .value (mag_q),
        .count (lzc_count)
    );
`endif

    // Fraction below the hidden one, padded so narrow inputs zero-fill
    // the mantissa and still leave a guard bit and a sticky field.
    always_comb begin
        ext       = {mag_q[IN_W-2:0], {(SR_MAN_W + 2){1'b0}}};
        man_trunc = ext[EXT_W-1 -: SR_MAN_W];
        guard     = ext[IN_W];
        sticky    = |ext[IN_W-1:0];
        round_up  = guard & (sticky | man_trunc[0]);
        man_sum   = {1'b0, man_trunc} + {{SR_MAN_W{1'b0}}, round_up};
        // Mantissa carry-out leaves man_sum[22:0] all zero; bump the exponent.
        exp_sum   = SR_EXP_W'(SR_BIAS + IN_W - 1)
                  - SR_EXP_W'(lz_q)
                  + SR_EXP_W'(man_sum[SR_MAN_W]);
        rnd_bits.sign = sign_q;
        rnd_bits.exp  = exp_sum;
        rnd_bits.man  = man_sum[SR_MAN_W-1:0];
    end

    always_comb begin
        state_d       = state_q;
        mag_d         = mag_q;
        lz_d          = lz_q;
        sign_d        = sign_q;
        out_bits_d    = out_bits_q;
        out_inexact_d = out_inexact_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    sign_d = in_data[IN_W-1];
                    // Unsigned view makes |-2^(IN_W-1)| = 2^(IN_W-1) exactly.
                    mag_d  = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
                    lz_d   = '0;
                    if (mag_d == '0) begin
                        out_bits_d    = '0;
                        out_inexact_d = 1'b0;
                        state_d       = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
`ifdef INT_TO_SHORTREAL_FAST_NORM_EN
                mag_d   = mag_q << lzc_count;
                lz_d    = lzc_count;
                state_d = ROUND;
`else
                if (mag_q[IN_W-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    lz_d  = lz_q + LZ_W'(1);
                end
`endif
            end
            ROUND: begin
                out_bits_d    = rnd_bits;
                out_inexact_d = guard | sticky;
                state_d       = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // out_valid trails entry into DONE by one cycle; drops after handshake.
        out_valid_d = (state_q == DONE) && !(out_valid_q && out_ready);
        in_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mag_q         <= '0;
            lz_q          <= '0;
            sign_q        <= 1'b0;
            out_bits_q    <= '0;
            out_inexact_q <= 1'b0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            lz_q          <= lz_d;
            sign_q        <= sign_d;
            out_bits_q    <= out_bits_d;
            out_inexact_q <= out_inexact_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_bits    = out_bits_q;
    assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_shortreal_enc.sv
// Bench for int_to_shortreal_enc: directed vectors, backpressure, async reset,
// and a sweep against the simulator's own integer-to-real conversion.
module tb_int_to_shortreal_enc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_bits;
    logic        out_inexact;

    int errors;
    int checks;

    int_to_shortreal_enc #(.IN_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bits    (out_bits),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Called at #1 after a rising edge.
    task automatic convert(input logic [31:0] x, output logic [31:0] bits,
                           output logic inx, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 8) begin
            @(posedge clk); #1;
            w++;
        end
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        bits = out_bits;
        inx  = out_inexact;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Reference from the simulator's exact int->double conversion,
    // then RNE-narrowed to single precision.
    task automatic ref_conv(input logic [31:0] x, output logic [31:0] bits,
                            output logic inx, output int lz);
        real         r;
        logic [63:0] d;
        int          p;
        logic [22:0] m;
        logic        g;
        logic        st;
        logic        up;
        logic [23:0] ms;
        logic [7:0]  e8;
        if (x == 32'h0) begin
            bits = 32'h0;
            inx  = 1'b0;
            lz   = 32;
        end else begin
            r  = real'($signed(x));
            d  = $realtobits(r);
            p  = int'(d[62:52]) - 1023;
            lz = 31 - p;
            m  = d[51:29];
            g  = d[28];
            st = |d[27:0];
            up = g & (st | m[0]);
            ms = {1'b0, m} + {23'h0, up};
            e8 = 8'(p + 127) + {7'h0, ms[23]};
            bits = {d[63], e8, ms[22:0]};
            inx  = g | st;
        end
    endtask

    function automatic int exp_lat(input logic [31:0] x, input int lz);
        if (x == 32'h0) return 1;
`ifdef INT_TO_SHORTREAL_FAST_NORM_EN
        return 3;
`else
        return lz + 3;
`endif
    endfunction

    logic [31:0] vin   [13];
    logic [31:0] vexp  [13];
    logic        vinx  [13];
    int          vlz   [13];

    initial begin
        logic [31:0] bits;
        logic        inx;
        int          lat;
        logic [31:0] rbits;
        logic        rinx;
        int          rlz;
        logic [31:0] x;

        errors = 0;
        checks = 0;

        vin[0]  = 32'd1;          vexp[0]  = 32'h3F800000; vinx[0]  = 0; vlz[0]  = 31;
        vin[1]  = 32'hFFFFFFFF;   vexp[1]  = 32'hBF800000; vinx[1]  = 0; vlz[1]  = 31;
        vin[2]  = 32'd38;         vexp[2]  = 32'h42180000; vinx[2]  = 0; vlz[2]  = 26;
        vin[3]  = 32'd0;          vexp[3]  = 32'h00000000; vinx[3]  = 0; vlz[3]  = 32;
        vin[4]  = 32'h80000000;   vexp[4]  = 32'hCF000000; vinx[4]  = 0; vlz[4]  = 0;
        vin[5]  = 32'h7FFFFFFF;   vexp[5]  = 32'h4F000000; vinx[5]  = 1; vlz[5]  = 1;
        vin[6]  = 32'd16777217;   vexp[6]  = 32'h4B800000; vinx[6]  = 1; vlz[6]  = 7;
        vin[7]  = 32'd16777219;   vexp[7]  = 32'h4B800002; vinx[7]  = 1; vlz[7]  = 7;
        vin[8]  = 32'd16777218;   vexp[8]  = 32'h4B800001; vinx[8]  = 0; vlz[8]  = 7;
        vin[9]  = 32'hFFFFFFDA;   vexp[9]  = 32'hC2180000; vinx[9]  = 0; vlz[9]  = 26;
        vin[10] = 32'd255;        vexp[10] = 32'h437F0000; vinx[10] = 0; vlz[10] = 24;
        vin[11] = 32'hFFFFFFFE;   vexp[11] = 32'hC0000000; vinx[11] = 0; vlz[11] = 30;
        vin[12] = 32'd16777216;   vexp[12] = 32'h4B800000; vinx[12] = 0; vlz[12] = 7;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        #12;
        chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_out_bits", out_bits, 32'h0);
        chk("rst_inexact", {31'h0, out_inexact}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            convert(vin[i], bits, inx, lat);
            chk($sformatf("dir%0d_bits", i), bits, vexp[i]);
            chk($sformatf("dir%0d_inexact", i), {31'h0, inx}, {31'h0, vinx[i]});
            chk($sformatf("dir%0d_latency", i), 32'(lat),
                32'(exp_lat(vin[i], vlz[i])));
        end

        in_data  = 32'd38;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_first_valid", {31'h0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 32'h12345678;
            @(posedge clk); #1;
            chk("bp_valid", {31'h0, out_valid}, 32'd1);
            chk("bp_bits", out_bits, 32'h42180000);
            chk("bp_in_ready", {31'h0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", {31'h0, in_ready}, 32'd1);
        chk("bp_release_valid", {31'h0, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_ghost", {31'h0, out_valid}, 32'd0);

        in_data  = 32'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_bits", out_bits, 32'h0);
        chk("arst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'h0, in_ready}, 32'd0);
        chk("arst_inexact", {31'h0, out_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_recover_ready", {31'h0, in_ready}, 32'd1);
        convert(32'd38, bits, inx, lat);
        chk("arst_after_bits", bits, 32'h42180000);
        chk("arst_after_lat", 32'(lat), 32'(exp_lat(32'd38, 26)));

        for (int n = 0; n < 800; n++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) x = -x;
            if ($urandom_range(0, 63) == 0) x = 32'h0;
            ref_conv(x, rbits, rinx, rlz);
            convert(x, bits, inx, lat);
            chk("sweep_bits", bits, rbits);
            chk("sweep_inexact", {31'h0, inx}, {31'h0, rinx});
            chk("sweep_latency", 32'(lat), 32'(exp_lat(x, rlz)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
